uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Purpose: shares one UART byte transmitter (hardware-handshake variant: txd/rxd/cts/rts) between NUM_REQ byte-stream requesters; round-robin grant, burst-limited, CTS-gated.

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_BURST, default 8, maximum bytes per grant (1..255).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i at bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  marks final byte of requester's packet.
REQ-008 req_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 tx_valid  output  1  byte presented to serializer.
REQ-010 tx_data  output  8  byte to serializer.
REQ-011 tx_ready  input  1  serializer accepts byte when tx_valid & tx_ready.
REQ-012 cts  input  1  clear-to-send from link, active-high, asynchronous to clk.
REQ-013 grant_id  output  clog2(NUM_REQ)  current/last granted requester.
REQ-014 busy  output  1  high while in SEND or tx_valid high.

Function
REQ-015 cts SHALL pass a 2-flop synchronizer; cts_s (second-stage output) is the only CTS value used internally.
REQ-016 FSM states: IDLE, SEND; no other states.
REQ-017 IDLE: if any req_valid high, grant SHALL go to the first requester with req_valid high searching from rr_ptr upward with wrap-around; next state SEND, grant_id updated on the same edge.
REQ-018 IDLE: req_ready all zero.
REQ-019 SEND: req_ready[g] = cts_s & (~tx_valid | tx_ready); all other req_ready bits zero.
REQ-020 Byte accept (req_valid[g] & req_ready[g]) SHALL load tx_data and set tx_valid on the next edge (latency 1 cycle).
REQ-021 tx_valid, once high, SHALL hold with tx_data stable until tx_ready; cts_s falling SHALL NOT drop a presented byte, it only blocks new accepts.
REQ-022 tx_valid & tx_ready with no simultaneous accept SHALL clear tx_valid; with simultaneous accept tx_valid stays high with new data (back-to-back, one byte per cycle).
REQ-023 burst_cnt (8 bit) SHALL reset to 0 on grant and increment per accepted byte.
REQ-024 Accepted byte with req_last[g] high, or with burst_cnt == MAX_BURST-1, SHALL end the grant: next state IDLE, rr_ptr = (g+1) mod NUM_REQ.
REQ-025 Grant SHALL be held while req_valid[g] is low in SEND; no timeout.
REQ-026 Grant may be re-issued from IDLE while tx_valid still high; new accepts wait per REQ-019.
REQ-027 Minimum turnaround: one IDLE cycle between consecutive grants.
REQ-028 Arbitration SHALL be fair: with all requesters continuously valid, grants SHALL cycle 0,1,...,NUM_REQ-1,0.

Reset
REQ-029 While rst high at an edge: state IDLE, rr_ptr 0, grant_id 0, burst_cnt 0, tx_valid 0, tx_data 0x00, req_ready 0, busy 0, synchronizer flops 0.
REQ-030 rst mid-burst SHALL discard any presented, unaccepted byte; no partial byte is re-sent after reset.
REQ-031 First accept possible no earlier than 3 cycles after rst release with cts high (synchronizer fill).

Verification
REQ-032 cts=1, tx_ready=1, only req 2 valid, 3 bytes 0xA1,0xA2,0xA3 with last on 0xA3 -> grant_id=2, tx_data A1,A2,A3 on consecutive cycles, then IDLE, rr_ptr=3.
REQ-033 All 4 requesters valid, packets of 2 bytes -> grant order 0,1,2,3,0; each grant carries exactly 2 bytes.
REQ-034 MAX_BURST=8, req 0 streams 20 bytes no last, req 1 valid -> grant 0 for 8 bytes, then req 1, then req 0 resumes at byte 9.
REQ-035 tx_valid=1 with 0x55, tx_ready=0, cts drops to 0 -> tx_data holds 0x55, req_ready stays 0 until cts_s returns; tx_ready=1 then completes 0x55 once.
REQ-036 rst asserted while tx_valid=1 mid-burst -> next cycle tx_valid=0, req_ready=0, grant_id=0, state IDLE; first accept after release no earlier than cycle 3.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ byte streams.
// Grants are burst-limited and new accepts are gated by a synchronized CTS.
module uart_tx_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  localparam int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  input  logic                 cts,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_SEND   = 1'b1;
  localparam logic [GW:0]   NUM_REQ_W = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0] LAST_ID   = GW'(NUM_REQ - 1);
  localparam logic [7:0]    BURST_END = 8'(MAX_BURST - 1);

  logic          cts_meta_reg;
  logic          cts_s_reg;
  logic [0:0]    state_reg;
  logic [GW-1:0] rr_ptr_reg;
  logic [GW-1:0] grant_reg;
  logic [7:0]    burst_cnt_reg;
  logic          tx_valid_reg;
  logic [7:0]    tx_data_reg;

  logic [7:0]    req_byte [NUM_REQ];
  logic [GW-1:0] pick_next;
  logic          pick_found;
  logic [GW:0]   cand;
  logic          send_slot;
  logic          accept;
  logic          end_burst;

  // The output slot is free when empty or being drained this cycle.
  assign send_slot = (state_reg == ST_SEND) && cts_s_reg && (!tx_valid_reg || tx_ready);
  assign accept    = send_slot && req_valid[grant_reg];
  assign end_burst = req_last[grant_reg] || (burst_cnt_reg == BURST_END);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_byte[gi]  = req_data[8*gi +: 8];
      assign req_ready[gi] = send_slot && (grant_reg == GW'(gi));
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_next  = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (GW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_next  = cand[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_reg  <= 1'b0;
      cts_s_reg     <= 1'b0;
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= 8'd0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      cts_meta_reg <= cts;
      cts_s_reg    <= cts_meta_reg;

      if (state_reg == ST_IDLE) begin
        if (pick_found) begin
          grant_reg     <= pick_next;
          burst_cnt_reg <= 8'd0;
          state_reg     <= ST_SEND;
        end
      end else if (accept) begin
        burst_cnt_reg <= burst_cnt_reg + 8'd1;
        if (end_burst) begin
          state_reg  <= ST_IDLE;
          rr_ptr_reg <= (grant_reg == LAST_ID) ? '0 : grant_reg + GW'(1);
        end
      end

      // A presented byte is only retired by tx_ready, never by CTS.
      if (accept) begin
        tx_valid_reg <= 1'b1;
        tx_data_reg  <= req_byte[grant_reg];
      end else if (tx_ready) begin
        tx_valid_reg <= 1'b0;
      end
    end
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg == ST_SEND) || tx_valid_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester byte sources, accept/transmit logs,
// compared against hand-built expected sequences.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        cts;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arb #(.NUM_REQ(4), .MAX_BURST(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .cts       (cts),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_data [4][32];
  int src_len [4];
  int src_pos [4];
  int src_pkt [4];

  int acc_req [$];
  int acc_dat [$];
  int tx_dat  [$];
  int tx_edge [$];
  int exp_req [$];
  int exp_dat [$];
  int first_acc_edge = -1;
  int cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Handshakes are sampled mid-cycle; they commit on the following edge (cyc+1).
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc_req.push_back(i);
          acc_dat.push_back(int'(req_data[8*i +: 8]));
          if (first_acc_edge < 0) first_acc_edge = cyc + 1;
        end
      end
      if (tx_valid && tx_ready) begin
        tx_dat.push_back(int'(tx_data));
        tx_edge.push_back(cyc + 1);
        $display("tx byte %02h at edge %0d (grant %0d)", tx_data, cyc + 1, grant_id);
      end
    end
  end

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (src_pos[i] < src_len[i]);
      req_data[8*i +: 8] = 8'h00;
      req_last[i]        = 1'b0;
      if (src_pos[i] < src_len[i]) begin
        req_data[8*i +: 8] = src_data[i][src_pos[i]];
        req_last[i] = (src_pkt[i] != 0) && (((src_pos[i] + 1) % src_pkt[i]) == 0);
      end
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (acc[i]) src_pos[i]++;
    end
    drive_srcs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int r, input int base, input int len, input int pkt);
    for (int k = 0; k < len; k++) src_data[r][k] = 8'(base + k);
    src_len[r] = len;
    src_pos[r] = 0;
    src_pkt[r] = pkt;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      src_pkt[i] = 0;
    end
  endtask

  task automatic clear_logs();
    acc_req.delete();
    acc_dat.delete();
    tx_dat.delete();
    tx_edge.delete();
    exp_req.delete();
    exp_dat.delete();
    first_acc_edge = -1;
  endtask

  task automatic expect_byte(input int r, input int d);
    exp_req.push_back(r);
    exp_dat.push_back(d);
  endtask

  task automatic compare_acc(input string tag);
    check({tag, "_acc_count"}, acc_dat.size(), exp_dat.size());
    for (int j = 0; j < exp_dat.size(); j++) begin
      check($sformatf("%s_req%0d", tag, j), (j < acc_req.size()) ? acc_req[j] : -1, exp_req[j]);
      check($sformatf("%s_dat%0d", tag, j), (j < acc_dat.size()) ? acc_dat[j] : -1, exp_dat[j]);
    end
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_tx_count"}, tx_dat.size(), exp_dat.size());
    for (int j = 0; j < exp_dat.size(); j++) begin
      check($sformatf("%s_tx%0d", tag, j), (j < tx_dat.size()) ? tx_dat[j] : -1, exp_dat[j]);
    end
  endtask

  initial begin
    rst = 1'b1; cts = 1'b1; tx_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    clear_srcs();

    // Single requester, 3-byte packet, held in reset first.
    load(2, 8'hA1, 3, 3);
    drive_srcs();
    run(3);
    check("rst_tx_valid",  tx_valid,  0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id",  grant_id,  0);
    check("rst_busy",      busy,      0);
    check("rst_tx_data",   tx_data,   0);
    clear_logs();
    rst = 1'b0;
    run(15);
    check("s1_first_acc_ge3", int'(first_acc_edge >= 3), 1);
    expect_byte(2, 8'hA1); expect_byte(2, 8'hA2); expect_byte(2, 8'hA3);
    compare_acc("s1");
    compare_tx("s1");
    check("s1_b2b", (tx_edge.size() >= 3) ? tx_edge[2] - tx_edge[0] : -1, 2);
    check("s1_grant_id", grant_id, 2);
    check("s1_busy_idle", busy, 0);

    // rr_ptr must now be 3: req 3 wins over req 0.
    clear_logs();
    load(0, 8'h10, 1, 1);
    load(3, 8'h30, 1, 1);
    drive_srcs();
    run(10);
    expect_byte(3, 8'h30); expect_byte(0, 8'h10);
    compare_acc("s2");
    check("s2_grant_id", grant_id, 0);

    // All requesters valid, 2-byte packets: fair rotation.
    rst = 1'b1;
    clear_srcs();
    for (int r = 0; r < 4; r++) load(r, r * 16, 4, 2);
    drive_srcs();
    run(2);
    clear_logs();
    rst = 1'b0;
    run(50);
    for (int j = 0; j < 16; j++) expect_byte((j / 2) % 4, ((j / 2) % 4) * 16 + (j / 8) * 2 + (j % 2));
    compare_acc("s3");

    // Burst limit: req 0 streams 20 bytes with no last, req 1 has a 2-byte packet.
    rst = 1'b1;
    clear_srcs();
    load(0, 8'h40, 20, 0);
    load(1, 8'h80, 2, 2);
    drive_srcs();
    run(2);
    clear_logs();
    rst = 1'b0;
    run(60);
    for (int k = 0; k < 8; k++) expect_byte(0, 8'h40 + k);
    expect_byte(1, 8'h80); expect_byte(1, 8'h81);
    for (int k = 8; k < 20; k++) expect_byte(0, 8'h40 + k);
    compare_acc("s4");

    // CTS drop while a byte is stalled on tx_ready.
    rst = 1'b1;
    tx_ready = 1'b0;
    clear_srcs();
    load(1, 8'h55, 2, 2);
    src_data[1][1] = 8'h66;
    drive_srcs();
    run(2);
    clear_logs();
    rst = 1'b0;
    run(6);
    check("s5_tx_valid_up", tx_valid, 1);
    cts = 1'b0;
    run(4);
    check("s5_hold_valid", tx_valid,  1);
    check("s5_hold_data",  tx_data,   8'h55);
    check("s5_hold_ready", req_ready, 0);
    check("s5_hold_txcnt", tx_dat.size(), 0);
    tx_ready = 1'b1;
    run(3);
    check("s5_once_txcnt", tx_dat.size(), 1);
    check("s5_once_data",  (tx_dat.size() > 0) ? tx_dat[0] : -1, 8'h55);
    check("s5_drain_valid", tx_valid, 0);
    check("s5_nocts_ready", req_ready, 0);
    cts = 1'b1;
    run(8);
    expect_byte(1, 8'h55); expect_byte(1, 8'h66);
    compare_tx("s5");
    check("s5_acc_count", acc_dat.size(), 2);

    // Reset mid-burst with a presented byte discards it.
    rst = 1'b1;
    tx_ready = 1'b0;
    clear_srcs();
    load(2, 8'h90, 4, 0);
    drive_srcs();
    run(2);
    clear_logs();
    rst = 1'b0;
    run(6);
    check("s6_pre_valid", tx_valid, 1);
    check("s6_pre_grant", grant_id, 2);
    rst = 1'b1;
    run(1);
    check("s6_rst_valid", tx_valid,  0);
    check("s6_rst_ready", req_ready, 0);
    check("s6_rst_grant", grant_id,  0);
    check("s6_rst_busy",  busy,      0);
    rst = 1'b0;
    clear_logs();
    tx_ready = 1'b1;
    run(12);
    check("s6_first_acc_ge3", int'(first_acc_edge >= 3), 1);
    expect_byte(2, 8'h91); expect_byte(2, 8'h92); expect_byte(2, 8'h93);
    compare_tx("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
